// File: rtl/cvrt_pkg.sv
// Shared types and limits for the binary/gray counter family.
package cvrt_pkg;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

  localparam int unsigned CVRT_MAX_WIDTH = 32;

endpackage : cvrt_pkg

// File: rtl/cvrt_bin_gry.sv
// Combinational binary-to-gray converter.
module cvrt_bin_gry #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_bin,
  output logic [DATA_WIDTH-1:0] o_gry
);

  assign o_gry = i_bin ^ (i_bin >> 1);

endmodule : cvrt_bin_gry

// File: rtl/cvrt_gry_cnt.sv
// Up/down counter holding binary and registered gray copies, with load,
// wrap pulse and a combinational next-gray preview for FIFO look-ahead.
module cvrt_gry_cnt
  import cvrt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned INIT_VAL   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_dir,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_bin,
  output logic [DATA_WIDTH-1:0] o_bin,
  output logic [DATA_WIDTH-1:0] o_gry,
  output logic [DATA_WIDTH-1:0] o_gry_nxt,
  output logic                  o_wrap
);

  if (DATA_WIDTH < 2 || DATA_WIDTH > CVRT_MAX_WIDTH) begin : g_bad_width
    $error("cvrt_gry_cnt: DATA_WIDTH out of range 2..%0d", CVRT_MAX_WIDTH);
  end
  if ((64'(INIT_VAL) >> DATA_WIDTH) != 64'd0) begin : g_bad_init
    $error("cvrt_gry_cnt: INIT_VAL does not fit in DATA_WIDTH bits");
  end

  localparam logic [DATA_WIDTH-1:0] INIT_BIN = DATA_WIDTH'(INIT_VAL);
  localparam logic [DATA_WIDTH-1:0] INIT_GRY = INIT_BIN ^ (INIT_BIN >> 1);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  cnt_dir_e              dir;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] gry_q, gry_d;
  logic                  wrap_q, wrap_d;
  logic [DATA_WIDTH-1:0] step_bin;
  logic                  step_wraps;
  logic [DATA_WIDTH-1:0] conv_bin;
  logic [DATA_WIDTH-1:0] conv_gry;

  assign dir = cnt_dir_e'(i_dir);

  always_comb begin
    step_bin   = (dir == CNT_UP) ? bin_q + ONE : bin_q - ONE;
    step_wraps = (dir == CNT_UP) ? (&bin_q) : (bin_q == '0);
  end

  // Load shares the register-side converter, so o_gry is always a flop fed by gray(next bin).
  assign conv_bin = i_load ? i_load_bin : step_bin;

  cvrt_bin_gry #(.DATA_WIDTH(DATA_WIDTH)) u_gry_reg (
    .i_bin (conv_bin),
    .o_gry (conv_gry)
  );

  cvrt_bin_gry #(.DATA_WIDTH(DATA_WIDTH)) u_gry_nxt (
    .i_bin (step_bin),
    .o_gry (o_gry_nxt)
  );

  always_comb begin
    bin_d  = bin_q;
    gry_d  = gry_q;
    wrap_d = 1'b0;
    if (i_load) begin
      bin_d = i_load_bin;
      gry_d = conv_gry;
    end else if (i_en) begin
      bin_d  = step_bin;
      gry_d  = conv_gry;
      wrap_d = step_wraps;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q  <= INIT_BIN;
      gry_q  <= INIT_GRY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gry_q  <= gry_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_bin  = bin_q;
  assign o_gry  = gry_q;
  assign o_wrap = wrap_q;

endmodule : cvrt_gry_cnt

// File: tb/tb_cvrt_gry_cnt.sv
// Directed and randomised checks of cvrt_gry_cnt at DATA_WIDTH = 4, INIT_VAL = 0.
module tb_cvrt_gry_cnt;

  logic       i_clk = 1'b0;
  logic       i_rst, i_en, i_dir, i_load;
  logic [3:0] i_load_bin;
  logic [3:0] o_bin, o_gry, o_gry_nxt;
  logic       o_wrap;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  cvrt_gry_cnt #(.DATA_WIDTH(4), .INIT_VAL(0)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_dir      (i_dir),
    .i_load     (i_load),
    .i_load_bin (i_load_bin),
    .o_bin      (o_bin),
    .o_gry      (o_gry),
    .o_gry_nxt  (o_gry_nxt),
    .o_wrap     (o_wrap)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b1; i_dir = 1'b1; i_load = 1'b0; i_load_bin = 4'h0;
    tick();
    tick();
    total++;
    if (o_bin !== 4'd0) begin bad++; $display("FAIL reset_bin got=%h want=0", o_bin); end
    total++;
    if (o_gry !== 4'b0000) begin bad++; $display("FAIL reset_gry got=%b want=0000", o_gry); end
    total++;
    if (o_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", o_wrap); end
    i_rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] gu [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
                            4'b1000, 4'b0000};
    logic [3:0] prev;
    prev = o_gry;
    i_en = 1'b1; i_dir = 1'b1; i_load = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++;
      if (o_bin !== 4'(i)) begin bad++; $display("FAIL up_bin step=%0d got=%0d want=%0d", i, o_bin, i % 16); end
      total++;
      if (o_gry !== gu[i-1]) begin bad++; $display("FAIL up_gry step=%0d got=%b want=%b", i, o_gry, gu[i-1]); end
      total++;
      if (o_wrap !== (i == 16)) begin bad++; $display("FAIL up_wrap step=%0d got=%b want=%b", i, o_wrap, (i == 16)); end
      total++;
      if ($countones(o_gry ^ prev) != 1) begin bad++; $display("FAIL up_onebit step=%0d prev=%b now=%b", i, prev, o_gry); end
      prev = o_gry;
    end
  endtask

  task automatic test_load_down();
    logic [3:0] bd [7] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    logic [3:0] gd [7] = '{4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1001};
    i_load = 1'b1; i_load_bin = 4'b0101; i_en = 1'b0;
    tick();
    i_load = 1'b0;
    total++;
    if (o_bin !== 4'd5) begin bad++; $display("FAIL load_bin got=%0d want=5", o_bin); end
    total++;
    if (o_gry !== 4'b0111) begin bad++; $display("FAIL load_gry got=%b want=0111", o_gry); end
    i_en = 1'b1; i_dir = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (o_bin !== bd[i]) begin bad++; $display("FAIL dn_bin step=%0d got=%0d want=%0d", i, o_bin, bd[i]); end
      total++;
      if (o_gry !== gd[i]) begin bad++; $display("FAIL dn_gry step=%0d got=%b want=%b", i, o_gry, gd[i]); end
      total++;
      if (o_wrap !== (i == 5)) begin bad++; $display("FAIL dn_wrap step=%0d got=%b want=%b", i, o_wrap, (i == 5)); end
    end
  endtask

  task automatic test_dir_preview();
    i_load = 1'b1; i_load_bin = 4'd6; i_en = 1'b0;
    tick();
    i_load = 1'b0; i_dir = 1'b1;
    #1;
    total++;
    if (o_gry_nxt !== 4'b0100) begin bad++; $display("FAIL nxt_up got=%b want=0100", o_gry_nxt); end
    i_dir = 1'b0;
    #1;
    total++;
    if (o_gry_nxt !== 4'b0111) begin bad++; $display("FAIL nxt_dn got=%b want=0111", o_gry_nxt); end
    tick();
    total++;
    if (o_bin !== 4'd6) begin bad++; $display("FAIL hold_bin got=%0d want=6", o_bin); end
    total++;
    if (o_gry !== 4'b0101) begin bad++; $display("FAIL hold_gry got=%b want=0101", o_gry); end
    total++;
    if (o_wrap !== 1'b0) begin bad++; $display("FAIL hold_wrap got=%b want=0", o_wrap); end
    // preview tracks i_dir even while load is asserted
    i_load = 1'b1; i_load_bin = 4'd9; i_dir = 1'b1;
    #1;
    total++;
    if (o_gry_nxt !== 4'b0100) begin bad++; $display("FAIL nxt_under_load got=%b want=0100", o_gry_nxt); end
    i_load = 1'b0;
  endtask

  task automatic test_load_en();
    i_load = 1'b1; i_en = 1'b1; i_dir = 1'b1; i_load_bin = 4'd9;
    tick();
    i_load = 1'b0; i_en = 1'b0;
    total++;
    if (o_bin !== 4'd9) begin bad++; $display("FAIL ldn_bin got=%0d want=9", o_bin); end
    total++;
    if (o_gry !== 4'b1101) begin bad++; $display("FAIL ldn_gry got=%b want=1101", o_gry); end
    total++;
    if (o_wrap !== 1'b0) begin bad++; $display("FAIL ldn_wrap got=%b want=0", o_wrap); end
  endtask

  task automatic test_rst_mid();
    i_load = 1'b1; i_load_bin = 4'd10;
    tick();
    i_load = 1'b0; i_en = 1'b1; i_dir = 1'b1;
    tick();
    total++;
    if (o_bin !== 4'd11) begin bad++; $display("FAIL pre_rst_bin got=%0d want=11", o_bin); end
    i_rst = 1'b1; i_load = 1'b1; i_load_bin = 4'd5;
    tick();
    i_rst = 1'b0; i_load = 1'b0;
    total++;
    if (o_bin !== 4'd0) begin bad++; $display("FAIL rst_mid_bin got=%0d want=0", o_bin); end
    total++;
    if (o_gry !== 4'b0000) begin bad++; $display("FAIL rst_mid_gry got=%b want=0000", o_gry); end
    total++;
    if (o_wrap !== 1'b0) begin bad++; $display("FAIL rst_mid_wrap got=%b want=0", o_wrap); end
    tick();
    total++;
    if (o_bin !== 4'd1 || o_gry !== 4'b0001) begin
      bad++; $display("FAIL rst_restart got=%0d/%b want=1/0001", o_bin, o_gry);
    end
  endtask

  task automatic test_back_to_back_wrap();
    i_load = 1'b1; i_load_bin = 4'd0; i_en = 1'b0;
    tick();
    i_load = 1'b0; i_en = 1'b1; i_dir = 1'b0;
    tick();
    total++;
    if (o_bin !== 4'd15 || o_wrap !== 1'b1) begin
      bad++; $display("FAIL b2b_dn got=%0d/%b want=15/1", o_bin, o_wrap);
    end
    i_dir = 1'b1;
    tick();
    total++;
    if (o_bin !== 4'd0 || o_gry !== 4'b0000 || o_wrap !== 1'b1) begin
      bad++; $display("FAIL b2b_up got=%0d/%b/%b want=0/0000/1", o_bin, o_gry, o_wrap);
    end
    i_en = 1'b0;
    tick();
    total++;
    if (o_bin !== 4'd0 || o_wrap !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%0d/%b want=0/0", o_bin, o_wrap);
    end
  endtask

  task automatic test_random();
    logic [3:0] m_bin, m_nxt, prev_gry;
    logic       m_wrap, stepped;
    m_bin = o_bin;
    for (int c = 0; c < 1000; c++) begin
      i_en       = 1'($urandom_range(0, 3) != 0);
      i_dir      = 1'($urandom_range(0, 1));
      i_load     = 1'($urandom_range(0, 7) == 0);
      i_load_bin = 4'($urandom_range(0, 15));
      m_nxt      = i_dir ? m_bin + 4'd1 : m_bin - 4'd1;
      #1;
      total++;
      if (o_gry_nxt !== (m_nxt ^ (m_nxt >> 1))) begin
        bad++; $display("FAIL rnd_nxt cyc=%0d got=%b want=%b", c, o_gry_nxt, m_nxt ^ (m_nxt >> 1));
      end
      prev_gry = o_gry;
      stepped  = i_en && !i_load;
      m_wrap   = stepped && (i_dir ? (m_bin == 4'd15) : (m_bin == 4'd0));
      if (i_load) m_bin = i_load_bin;
      else if (i_en) m_bin = m_nxt;
      tick();
      total++;
      if (o_bin !== m_bin || o_wrap !== m_wrap) begin
        bad++; $display("FAIL rnd_state cyc=%0d got=%0d/%b want=%0d/%b", c, o_bin, o_wrap, m_bin, m_wrap);
      end
      total++;
      if (o_gry !== (o_bin ^ (o_bin >> 1))) begin
        bad++; $display("FAIL rnd_gray cyc=%0d bin=%0d gry=%b", c, o_bin, o_gry);
      end
      if (stepped) begin
        total++;
        if ($countones(o_gry ^ prev_gry) != 1) begin
          bad++; $display("FAIL rnd_onebit cyc=%0d prev=%b now=%b", c, prev_gry, o_gry);
        end
      end
    end
    i_en = 1'b0; i_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_dir_preview();
    test_load_en();
    test_rst_mid();
    test_back_to_back_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cvrt_gry_cnt

// File: doc/cvrt_gry_cnt.md
Name: cvrt_gry_cnt

Overview:
- Parametrised up/down counter that holds its state in binary and gray form at the same time.
- The gray output is registered directly, so it is glitch-free and safe to sample from another clock domain (async FIFO pointers, CDC position tags).
- Adds enable, direction, synchronous load, wrap indication and a next-gray preview, none of which the plain combinational bin-to-gray converter provides.
- Sits between the FIFO read/write control logic and the CDC synchronisers.

Parameters:
- DATA_WIDTH, 4, counter width in bits; legal range 2..32.
- INIT_VAL, 0, binary reset value; must be < 2**DATA_WIDTH.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_en  input  1  count enable; one step per cycle while high.
- i_dir  input  1  1 = count up, 0 = count down.
- i_load  input  1  synchronous load strobe.
- i_load_bin  input  DATA_WIDTH  binary value to load.
- o_bin  output  DATA_WIDTH  registered binary count.
- o_gry  output  DATA_WIDTH  registered gray count; always equals gray(o_bin).
- o_gry_nxt  output  DATA_WIDTH  combinational gray of the value after one step in direction i_dir.
- o_wrap  output  1  registered one-cycle pulse: the last step wrapped.

Behaviour:
- Reset is synchronous and active-high on i_clk. While i_rst = 1 at an edge:
  - o_bin <= INIT_VAL
  - o_gry <= INIT_VAL ^ (INIT_VAL >> 1)
  - o_wrap <= 0
- Priority per edge: i_rst > i_load > i_en. Inputs are sampled only at the rising edge.
- Load (i_load = 1):
  - o_bin <= i_load_bin; o_gry <= gray(i_load_bin); o_wrap <= 0.
  - i_en and i_dir are ignored that cycle.
- Count (i_en = 1, no load):
  - Up: o_bin <= o_bin + 1, modulo 2**DATA_WIDTH.
  - Down: o_bin <= o_bin - 1, modulo 2**DATA_WIDTH.
  - o_gry <= gray of the new binary value.
  - Latency is one cycle; o_bin and o_gry update on the same edge.
- Idle (i_en = 0, no load): all registers hold; o_wrap <= 0.
- Wrap:
  - o_wrap <= 1 on an up-step from all-ones, or a down-step from zero. Otherwise o_wrap <= 0.
  - It is a one-cycle pulse, re-asserted on every wrapping step.
- Gray invariant:
  - Every count step changes exactly one bit of o_gry.
  - o_gry is a flop output, never a combinational decode of o_bin.
- o_gry_nxt:
  - Equals gray(o_bin ± 1), signed by i_dir, independent of i_en and i_load.
  - Used for FIFO full/empty look-ahead. It follows i_dir combinationally in the same cycle.
- Reset mid-count overrides any load or enable at that edge. The count restarts at INIT_VAL on the next edge.
- A direction change between consecutive enabled cycles is legal; there is no dead cycle.
- All arithmetic is unsigned, DATA_WIDTH bits, with carry and borrow discarded.

Decomposition:
- Package cvrt_pkg holds:
  - typedef enum logic {CNT_DN = 1'b0, CNT_UP = 1'b1} cnt_dir_e
  - localparam CVRT_MAX_WIDTH = 32, used for parameter range checks
- Sub-module: reuse the existing cvrt_bin_gry (parameter DATA_WIDTH).
  - Two instances: one converts the next binary value into the o_gry register input, one produces o_gry_nxt.
  - The load path shares the first instance through a mux in front of it.
- No other sub-modules.

Test Plan (DATA_WIDTH = 4, INIT_VAL = 0):
- Reset then 16 cycles of i_en = 1, i_dir = 1:
  - o_bin steps 0..15 then back to 0; o_gry follows 0000, 0001, 0011, 0010, ..., 1000, 0000.
  - o_wrap pulses only in the cycle after 15 -> 0.
  - Exactly one bit of o_gry flips per cycle.
- i_load = 1 with i_load_bin = 4'b0101, then i_en = 1, i_dir = 0 for 7 cycles:
  - o_bin goes 5, 4, 3, 2, 1, 0, 15, 14; o_gry after load is 0111.
  - o_wrap = 1 only after the 0 -> 15 step.
- With o_bin = 6, toggle i_dir while i_en = 0:
  - o_gry_nxt = 0100 (gray 7) when i_dir = 1, 0111 (gray 5) when i_dir = 0.
  - o_bin and o_gry hold.
- i_load = 1 and i_en = 1 in the same cycle with i_load_bin = 9:
  - Next o_bin = 9, o_gry = 1101, o_wrap = 0.
- i_rst = 1 asserted together with i_load = 1 while counting at o_bin = 11:
  - Next o_bin = 0, o_gry = 0000, o_wrap = 0.
- Randomised 1000 cycles of en/dir/load:
  - Scoreboard checks o_gry == o_bin ^ (o_bin >> 1) every cycle.
  - Scoreboard checks a single-bit gray delta on every count step.
